// File: rtl/trap_service_pkg.sv
// Shared definitions for the trap flag / trap service path: FSM state
// encoding, trap-number constants, vector base and the positions of the
// PC trap flags 9:10 inside the two-bit trap_flags vector.
package trap_service_pkg;

    // Word offset of the trap vectors in the EPT/UPT (trap n lives at 420+n).
    localparam logic [8:0] VEC_BASE_DEFAULT = 9'o420;

    // PC flag numbers of the two trap bits and their index in trap_flags[0:1].
    localparam int FLAG_PDL_BIT = 9;
    localparam int FLAG_OVF_BIT = 10;
    localparam int PDL_IDX      = FLAG_PDL_BIT - 9;
    localparam int OVF_IDX      = FLAG_OVF_BIT - 9;

    // Trap number zero means "no trap pending".
    localparam logic [1:0] TRAP_NONE = 2'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_LOAD
    } trapState_t;

    // Word offset of the vector for trap number n.
    function automatic logic [8:0] vecOffset(input logic [8:0] base, input logic [1:0] n);
        return base + {7'd0, n};
    endfunction

endpackage

// File: rtl/trap_service_if.sv
// Memory read bus between the trap service (master) and the bus interface
// (slave). The request is held until acknowledged or abandoned.
interface trap_service_if #(
    parameter int PAGE_WIDTH = 11
);
    logic                  bus_req;
    logic [PAGE_WIDTH+8:0] bus_addr;
    logic                  bus_ack;
    logic [0:35]           bus_data;

    modport master (
        output bus_req,
        output bus_addr,
        input  bus_ack,
        input  bus_data
    );

    modport slave (
        input  bus_req,
        input  bus_addr,
        output bus_ack,
        output bus_data
    );
endinterface

// File: rtl/trap_service_flag_reg.sv
// PC trap flags 9:10. A flag restore overrides everything; otherwise the
// serviced trap bits are cleared and new overflow events are OR-ed in, so an
// event arriving in the same cycle as the clear is never lost.
module trap_service_flag_reg
    import trap_service_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clken,
    input  logic       set_ovf,
    input  logic       set_pdl,
    input  logic       flags_load,
    input  logic [0:1] flags_in,
    input  logic [0:1] clearMask,
    output logic [0:1] flags
);

    logic [0:1] setMask;

    // Place the event strobes at their flag positions.
    always_comb begin
        setMask          = 2'b00;
        setMask[PDL_IDX] = set_pdl;
        setMask[OVF_IDX] = set_ovf;
    end

    // Flag register: restore > (clear serviced, then set new events).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags <= 2'b00;
        end else if (clken) begin
            if (flags_load) begin
                flags <= flags_in;
            end else begin
                flags <= (flags & ~clearMask) | setMask;
            end
        end
    end

endmodule

// File: rtl/trap_service.sv
// Trap service: on a trap cycle with a pending trap, fetch the trap
// instruction from EPT/UPT word 420+n, hand it to the IR path and clear the
// serviced trap bits. A fetch that is never acknowledged is abandoned after
// TIMEOUT wait cycles with an NXM strobe, leaving the flags untouched.
module trap_service
    import trap_service_pkg::*;
#(
    parameter int         PAGE_WIDTH = 11,
    parameter logic [8:0] VEC_BASE   = VEC_BASE_DEFAULT,
    parameter int         TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clken,
    input  logic                  set_ovf,
    input  logic                  set_pdl,
    input  logic                  flags_load,
    input  logic [0:1]            flags_in,
    input  logic                  trap_cycle,
    input  logic                  ni_load,
    input  logic                  user_mode,
    input  logic [PAGE_WIDTH-1:0] ept_page,
    input  logic [PAGE_WIDTH-1:0] upt_page,
    output logic [0:1]            trap_flags,
    output logic                  ir_load,
    output logic [0:35]           ir_data,
    output logic                  busy,
    output logic                  nxm,
    trap_service_if.master        bus
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    trapState_t            state;
    logic [1:0]            trapNum;
    logic [CNT_W-1:0]      waitCnt;
    logic [0:1]            clearMask;
    logic                  busReq;
    logic [PAGE_WIDTH+8:0] busAddr;

    // Only the trap actually being serviced is cleared, and only on LOAD.
    assign clearMask = (state == ST_LOAD) ? trapNum : 2'b00;

    trap_service_flag_reg u_flags (
        .clk       (clk),
        .rst       (rst),
        .clken     (clken),
        .set_ovf   (set_ovf),
        .set_pdl   (set_pdl),
        .flags_load(flags_load),
        .flags_in  (flags_in),
        .clearMask (clearMask),
        .flags     (trap_flags)
    );

    assign bus.bus_req  = busReq;
    assign bus.bus_addr = busAddr;
    assign busy         = (state != ST_IDLE);

    // Service FSM with registered bus request, address latch, IR capture,
    // strobes and the saturating wait counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            trapNum <= TRAP_NONE;
            waitCnt <= '0;
            busReq  <= 1'b0;
            busAddr <= '0;
            ir_load <= 1'b0;
            ir_data <= '0;
            nxm     <= 1'b0;
        end else if (clken) begin
            ir_load <= 1'b0;
            nxm     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ni_load && trap_cycle && (trap_flags != TRAP_NONE)) begin
                        trapNum <= trap_flags;
                        busAddr <= {user_mode ? upt_page : ept_page,
                                    vecOffset(VEC_BASE, trap_flags)};
                        busReq  <= 1'b1;
                        state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    waitCnt <= '0;
                    state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.bus_ack) begin
                        ir_data <= bus.bus_data;
                        ir_load <= 1'b1;
                        busReq  <= 1'b0;
                        state   <= ST_LOAD;
                    end else if (waitCnt == CNT_LAST) begin
                        nxm    <= 1'b1;
                        busReq <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                    end
                end
                ST_LOAD: begin
                    state <= ST_IDLE;
                end
                default: begin
                    busReq <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trap_service.sv
// Bench for trap_service: expected vector addresses and trap instruction
// words are queued when a service is started and compared by a monitor when
// the DUT raises bus_req / ir_load.
module tb_trap_service;
    import trap_service_pkg::*;

    localparam int PW = 11;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst, clken, set_ovf, set_pdl, flags_load;
    logic [0:1]    flags_in;
    logic          trap_cycle, ni_load, user_mode;
    logic [PW-1:0] ept_page, upt_page;
    logic [0:1]    trap_flags;
    logic          ir_load;
    logic [0:35]   ir_data;
    logic          busy, nxm;

    trap_service_if #(.PAGE_WIDTH(PW)) bus ();

    trap_service #(.PAGE_WIDTH(PW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .clken     (clken),
        .set_ovf   (set_ovf),
        .set_pdl   (set_pdl),
        .flags_load(flags_load),
        .flags_in  (flags_in),
        .trap_cycle(trap_cycle),
        .ni_load   (ni_load),
        .user_mode (user_mode),
        .ept_page  (ept_page),
        .upt_page  (upt_page),
        .trap_flags(trap_flags),
        .ir_load   (ir_load),
        .ir_data   (ir_data),
        .busy      (busy),
        .nxm       (nxm),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int passCount  = 0;
    int checkCount = 0;
    int irLoadSeen = 0;
    int nxmSeen    = 0;
    logic [35:0] expWordQ[$];
    logic [19:0] expAddrQ[$];
    logic        prevReq = 1'b0;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got === exp) begin
            passCount++;
            $display("check %s: got %0h expected %0h ok", tag, got, exp);
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare address on each new request and word on each ir_load.
    always @(negedge clk) begin
        if (bus.bus_req && !prevReq) begin
            if (expAddrQ.size() == 0) checkVal("unexpected_req", 1, 0);
            else checkVal("bus_addr", bus.bus_addr, expAddrQ.pop_front());
        end
        prevReq = bus.bus_req;
        if (ir_load) begin
            irLoadSeen++;
            if (expWordQ.size() == 0) checkVal("unexpected_ir_load", 1, 0);
            else checkVal("ir_data", ir_data, expWordQ.pop_front());
        end
        if (nxm) nxmSeen++;
    end

    // Full trap service with the ack after ackDelay wait cycles.
    task automatic service(input logic um, input int ackDelay, input logic [35:0] word,
                           input logic pdlInLoad);
        user_mode  = um;
        trap_cycle = 1'b1;
        ni_load    = 1'b1;
        step();
        trap_cycle = 1'b0;
        ni_load    = 1'b0;
        checkVal("busy_in_req", busy, 1);
        step();
        repeat (ackDelay) step();
        bus.bus_ack  = 1'b1;
        bus.bus_data = word;
        step();
        bus.bus_ack = 1'b0;
        checkVal("ir_load_latency", ir_load, 1);
        set_pdl = pdlInLoad;
        step();
        set_pdl = 1'b0;
        checkVal("idle_after_load", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int firstNxm;
        rst = 1'b1; clken = 1'b1; set_ovf = 1'b0; set_pdl = 1'b0; flags_load = 1'b0;
        flags_in = 2'b00; trap_cycle = 1'b0; ni_load = 1'b0; user_mode = 1'b0;
        ept_page = 11'o3; upt_page = 11'o7;
        bus.bus_ack = 1'b0; bus.bus_data = '0;
        repeat (2) step();
        checkVal("rst_flags", trap_flags, 0);
        checkVal("rst_req", bus.bus_req, 0);
        checkVal("rst_addr", bus.bus_addr, 0);
        checkVal("rst_busy", busy, 0);
        checkVal("rst_ir", {ir_load, nxm, ir_data}, 0);
        rst = 1'b0;
        step();

        // 1: overflow trap via EPT
        set_ovf = 1'b1; step(); set_ovf = 1'b0;
        checkVal("t1_flags", trap_flags, 2'b01);
        expAddrQ.push_back(20'o3421);
        expWordQ.push_back(36'o254000001000);
        service(1'b0, 0, 36'o254000001000, 1'b0);
        checkVal("t1_flags_clr", trap_flags, 2'b00);

        // 2: both traps via UPT
        set_ovf = 1'b1; set_pdl = 1'b1; step(); set_ovf = 1'b0; set_pdl = 1'b0;
        checkVal("t2_flags", trap_flags, 2'b11);
        expAddrQ.push_back(20'o7423);
        expWordQ.push_back(36'o123456701234);
        service(1'b1, 2, 36'o123456701234, 1'b0);
        checkVal("t2_flags_clr", trap_flags, 2'b00);

        // 3: pushdown trap, never acknowledged
        set_pdl = 1'b1; step(); set_pdl = 1'b0;
        checkVal("t3_flags", trap_flags, 2'b10);
        expAddrQ.push_back(20'o3422);
        user_mode = 1'b0; trap_cycle = 1'b1; ni_load = 1'b1;
        step();
        trap_cycle = 1'b0; ni_load = 1'b0;
        step();
        firstNxm = 0;
        for (int i = 1; i <= TO + 3; i++) begin
            step();
            if (nxm && firstNxm == 0) firstNxm = i;
        end
        checkVal("t3_nxm_cycle", firstNxm, TO);
        checkVal("t3_nxm_count", nxmSeen, 1);
        checkVal("t3_idle", {busy, bus.bus_req}, 0);
        checkVal("t3_flags_kept", trap_flags, 2'b10);
        checkVal("t3_no_ir", irLoadSeen, 2);

        // 4: set in LOAD cycle survives; restore beats a set
        flags_load = 1'b1; flags_in = 2'b01; step(); flags_load = 1'b0;
        checkVal("t4_restore", trap_flags, 2'b01);
        expAddrQ.push_back(20'o3421);
        expWordQ.push_back(36'o777000000042);
        service(1'b0, 1, 36'o777000000042, 1'b1);
        checkVal("t4_pdl_survives", trap_flags, 2'b10);
        flags_load = 1'b1; flags_in = 2'b01; set_pdl = 1'b1;
        step();
        flags_load = 1'b0; set_pdl = 1'b0;
        checkVal("t4_load_wins", trap_flags, 2'b01);

        // 5: reset in WAIT
        expAddrQ.push_back(20'o3421);
        trap_cycle = 1'b1; ni_load = 1'b1;
        step();
        trap_cycle = 1'b0; ni_load = 1'b0;
        step(); step();
        rst = 1'b1;
        #1;
        checkVal("t5_req_async", bus.bus_req, 0);
        checkVal("t5_outs", {trap_flags, busy, ir_load, nxm}, 0);
        bus.bus_ack = 1'b1; bus.bus_data = 36'o111111111111;
        step(); step();
        rst = 1'b0;
        step(); step();
        bus.bus_ack = 1'b0;
        checkVal("t5_late_ack", {busy, bus.bus_req, ir_data}, 0);
        checkVal("t5_ir_count", irLoadSeen, 3);

        // 6: clock enable low freezes everything; ni_load while busy ignored
        set_ovf = 1'b1; step(); set_ovf = 1'b0;
        clken = 1'b0; set_pdl = 1'b1; trap_cycle = 1'b1; ni_load = 1'b1;
        step(); step();
        set_pdl = 1'b0; trap_cycle = 1'b0; ni_load = 1'b0;
        checkVal("t6_frozen", {trap_flags, busy, bus.bus_req}, 4'b0100);
        clken = 1'b1;
        expAddrQ.push_back(20'o3421);
        expWordQ.push_back(36'o000000000777);
        trap_cycle = 1'b1; ni_load = 1'b1;
        step();
        trap_cycle = 1'b0; ni_load = 1'b0;
        step();
        ept_page = 11'o5; trap_cycle = 1'b1; ni_load = 1'b1;
        step();
        trap_cycle = 1'b0; ni_load = 1'b0;
        checkVal("t6_addr_stable", bus.bus_addr, 20'o3421);
        clken = 1'b0; bus.bus_ack = 1'b1; bus.bus_data = 36'o000000000777;
        step(); step();
        checkVal("t6_ack_gated", {ir_load, busy}, 2'b01);
        clken = 1'b1;
        step();
        bus.bus_ack = 1'b0;
        checkVal("t6_ir_load", ir_load, 1);
        step();
        checkVal("t6_flags_clr", trap_flags, 2'b00);
        step();
        checkVal("total_ir_loads", irLoadSeen, 4);
        checkVal("queues_drained", expWordQ.size() + expAddrQ.size(), 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
